// File: rtl/tt_um_example_cpu.sv
// Tiny Tapeout tile wrapping an 8-bit single-cycle CPU running a fixed 16-word ROM program.
// The ALU result is combinational from the current PC; PC and register write-back update on each rising edge.

module cpu_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rs,
  input  logic [2:0] rt,
  input  logic [2:0] rd,
  input  logic       reg_write,
  input  logic [7:0] wr_data,
  output logic [7:0] rs_data,
  output logic [7:0] rt_data
);

  logic [7:0] registers   [0:7];
  logic [7:0] registers_d [0:7];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      registers_d[i] = registers[i];
    end
    if (reg_write) begin
      registers_d[rd] = wr_data;
    end
  end

  // Reset seeds each register with its own index so the program has operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= 8'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        registers[i] <= registers_d[i];
      end
    end
  end

  assign rs_data = registers[rs];
  assign rt_data = registers[rt];

endmodule

module cpu_alu (
  input  logic [1:0] alu_op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  always_comb begin
    result = 8'h00;
    case (alu_op)
      2'b00:   result = a + b;
      2'b01:   result = a - b;
      2'b10:   result = a & b;
      2'b11:   result = a | b;
      default: result = 8'h00;
    endcase
  end

endmodule

module cpu_processor (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] pc,
  output logic [7:0] alu_result
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;
  logic [7:0] data;
  logic [1:0] opcode;
  logic [1:0] alu_op;
  logic       reg_write;
  logic [2:0] rs;
  logic [2:0] rt;
  logic [2:0] rd;
  logic [7:0] rs_data;
  logic [7:0] rt_data;

  // ROM repeats every 16 PCs; only the low nibble addresses it.
  always_comb begin
    data = 8'h00;
    case (pc_q[3:0])
      4'd0:    data = 8'h0A;
      4'd1:    data = 8'h59;
      4'd2:    data = 8'hA5;
      4'd3:    data = 8'hF7;
      4'd4:    data = 8'h3F;
      4'd5:    data = 8'h42;
      default: data = 8'h00;
    endcase
  end

  assign opcode    = data[7:6];
  assign rs        = data[5:3];
  assign rt        = data[2:0];
  assign rd        = rs;
  assign alu_op    = opcode;
  assign reg_write = 1'b1;

  cpu_regfile rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .reg_write (reg_write),
    .wr_data   (alu_result),
    .rs_data   (rs_data),
    .rt_data   (rt_data)
  );

  cpu_alu alu (
    .alu_op (alu_op),
    .a      (rs_data),
    .b      (rt_data),
    .result (alu_result)
  );

  always_comb begin
    pc_d = pc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 8'h00;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

module tt_um_example_cpu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] pc;
  logic [7:0] alu_result;
  logic       unused_inputs;

  // Tile inputs are not consumed; the core free-runs whenever clocked.
  assign unused_inputs = &{ena, ui_in, uio_in, 1'b0};

  cpu_processor processor (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .alu_result (alu_result)
  );

  assign uo_out  = alu_result;
  assign uio_out = pc;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_example_cpu.sv
// Directed bench for tt_um_example_cpu: reset values, program trace, ROM/PC wrap and mid-run reset.

module tb_tt_um_example_cpu;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int errors;

  tt_um_example_cpu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_r%0d", tag, i), dut.processor.rf.registers[i], 8'(i));
    end
  endtask

  initial begin
    logic [7:0] exp_pc  [0:5];
    int         exp_idx [0:5];
    logic [7:0] exp_reg [0:5];
    logic [7:0] exp_uo  [0:5];
    logic [7:0] chain_r0 [0:2];
    logic [7:0] chain_uo [0:2];

    exp_pc  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    exp_idx = '{1, 3, 4, 6, 7, 0};
    exp_reg = '{8'd3, 8'd0, 8'd4, 8'd7, 8'd14, 8'd254};
    exp_uo  = '{8'd0, 8'd4, 8'd7, 8'd14, 8'd254, 8'd252};
    chain_r0 = '{8'd252, 8'd248, 8'd240};
    chain_uo = '{8'd248, 8'd240, 8'd224};

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    #12;
    check_reset_regs("rst");
    check("rst_pc", uio_out, 8'd0);
    check("rst_uo", uo_out, 8'd3);
    check("rst_oe", uio_oe, 8'hFF);

    @(negedge clk);
    rst_n = 1'b1;

    for (int e = 0; e < 6; e++) begin
      tick();
      check($sformatf("e%0d_pc", e + 1), uio_out, exp_pc[e]);
      check($sformatf("e%0d_reg", e + 1), dut.processor.rf.registers[exp_idx[e]], exp_reg[e]);
      check($sformatf("e%0d_uo", e + 1), uo_out, exp_uo[e]);
    end

    for (int e = 0; e < 3; e++) begin
      tick();
      check($sformatf("ovf%0d_r0", e + 7), dut.processor.rf.registers[0], chain_r0[e]);
      check($sformatf("ovf%0d_uo", e + 7), uo_out, chain_uo[e]);
    end
    check("run_oe", uio_oe, 8'hFF);

    for (int e = 10; e <= 16; e++) tick();
    check("wrap16_pc", uio_out, 8'd16);
    check("wrap16_uo", uo_out, 8'd5);

    tick();
    check("e17_pc", uio_out, 8'd17);
    check("e17_r1", dut.processor.rf.registers[1], 8'd5);
    check("e17_uo", uo_out, 8'd251);

    for (int e = 18; e <= 256; e++) tick();
    check("pc_wrap", uio_out, 8'd0);

    for (int e = 0; e < 20; e++) tick();
    check("pre_rst_pc", uio_out, 8'd20);

    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", uio_out, 8'd0);
    check("mid_rst_uo", uo_out, 8'd3);
    check_reset_regs("mid_rst");
    #9;
    rst_n = 1'b1;

    tick();
    check("restart_pc", uio_out, 8'd1);
    check("restart_r1", dut.processor.rf.registers[1], 8'd3);
    check("restart_uo", uo_out, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
